// File: rtl/mips_core.sv
`default_nettype none
// ============================================================================
// Module  : mips_core
// Brief   : Single-cycle 32-bit MIPS integer core, harvard-style memory ports.
//           Optional jal support is enabled by defining MIPS_JAL_EN.
// Revision: 1.0 - initial release
// ============================================================================
module mips_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] pc,
   input  logic [31:0] instr,
   output logic        memWrite,
   output logic [31:0] aluout,
   output logic [31:0] writeData,
   input  logic [31:0] readData
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_JAL_EN
   localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_NONE = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_AND  = 3'd3;
   localparam logic [2:0] ALU_OR   = 3'd4;
   localparam logic [2:0] ALU_SLT  = 3'd5;

   logic [31:0] pc_q, pc_d;
   logic [31:0] regs_q [32];

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm;
   logic        unused_shamt;

   assign op    = instr[31:26];
   assign rs    = instr[25:21];
   assign rt    = instr[20:16];
   assign rd    = instr[15:11];
   assign funct = instr[5:0];
   assign imm   = instr[15:0];
   assign unused_shamt = ^instr[10:6];

   logic       reg_write, dst_rd, mem_to_reg, src_imm, zero_ext;
   logic       is_branch, is_jump, is_link, is_store;
   logic [2:0] alu_ctl;

   always_comb begin
      reg_write  = 1'b0;
      dst_rd     = 1'b0;
      mem_to_reg = 1'b0;
      src_imm    = 1'b0;
      zero_ext   = 1'b0;
      is_branch  = 1'b0;
      is_jump    = 1'b0;
      is_link    = 1'b0;
      is_store   = 1'b0;
      alu_ctl    = ALU_NONE;
      case (op)
         OP_RTYPE: begin
            reg_write = 1'b1;
            dst_rd    = 1'b1;
            case (funct)
               FN_ADD:  alu_ctl = ALU_ADD;
               FN_SUB:  alu_ctl = ALU_SUB;
               FN_AND:  alu_ctl = ALU_AND;
               FN_OR:   alu_ctl = ALU_OR;
               FN_SLT:  alu_ctl = ALU_SLT;
               default: reg_write = 1'b0;
            endcase
         end
         OP_ADDI: begin reg_write = 1'b1; src_imm = 1'b1; alu_ctl = ALU_ADD; end
         OP_SLTI: begin reg_write = 1'b1; src_imm = 1'b1; alu_ctl = ALU_SLT; end
         OP_ORI: begin
            reg_write = 1'b1;
            src_imm   = 1'b1;
            zero_ext  = 1'b1;
            alu_ctl   = ALU_OR;
         end
         OP_LW: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            src_imm    = 1'b1;
            alu_ctl    = ALU_ADD;
         end
         OP_SW:  begin is_store = 1'b1; src_imm = 1'b1; alu_ctl = ALU_ADD; end
         OP_BEQ: begin is_branch = 1'b1; alu_ctl = ALU_SUB; end
         OP_J:   is_jump = 1'b1;
`ifdef MIPS_JAL_EN
         OP_JAL: begin is_jump = 1'b1; is_link = 1'b1; reg_write = 1'b1; end
`endif
         default: ;
      endcase
   end

   logic [31:0] rs_val, rt_val, imm_ext, alu_b, alu_res;

   assign rs_val  = regs_q[rs];
   assign rt_val  = regs_q[rt];
   assign imm_ext = zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
   assign alu_b   = src_imm ? imm_ext : rt_val;

   always_comb begin
      alu_res = 32'h0000_0000;
      case (alu_ctl)
         ALU_ADD: alu_res = rs_val + alu_b;
         ALU_SUB: alu_res = rs_val - alu_b;
         ALU_AND: alu_res = rs_val & alu_b;
         ALU_OR:  alu_res = rs_val | alu_b;
         ALU_SLT: alu_res = {31'd0, $signed(rs_val) < $signed(alu_b)};
         default: alu_res = 32'h0000_0000;
      endcase
   end

   logic [31:0] pc_plus4, branch_target, jump_target, wr_data;
   logic [4:0]  wr_addr;

   assign pc_plus4      = pc_q + 32'd4;
   assign branch_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
   assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

   always_comb begin
      pc_d = pc_plus4;
      if (is_jump)
         pc_d = jump_target;
      else if (is_branch && (alu_res == 32'h0000_0000))
         pc_d = branch_target;
   end

   assign wr_addr = is_link ? 5'd31 : (dst_rd ? rd : rt);
   assign wr_data = is_link ? pc_plus4 : (mem_to_reg ? readData : alu_res);

   // $0 is cleared on reset and never written, so reads of it stay zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= RESET_PC;
         for (int i = 0; i < 32; i++)
            regs_q[i] <= 32'h0000_0000;
      end else begin
         pc_q <= pc_d;
         if (reg_write && (wr_addr != 5'd0))
            regs_q[wr_addr] <= wr_data;
      end
   end

   assign pc        = pc_q;
   assign aluout    = alu_res;
   assign writeData = rt_val;
   assign memWrite  = is_store & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_mips_core.sv
`default_nettype none
// tb_mips_core: directed and randomized instruction streams checked against
// an instruction-level architectural model of the core.
module tb_mips_core;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instr = 32'h0;
   logic [31:0] readData = 32'h0;
   logic [31:0] pc, aluout, writeData;
   logic        memWrite;

   always #5 clk = ~clk;

   mips_core #(.RESET_PC(32'h0000_0000)) dut (
      .clk       (clk),
      .reset     (reset),
      .pc        (pc),
      .instr     (instr),
      .memWrite  (memWrite),
      .aluout    (aluout),
      .writeData (writeData),
      .readData  (readData)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] m_regs [32];
   logic [31:0] m_pc;
   logic [31:0] last_alu, last_wd, last_mw;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Executes one instruction on the DUT and on the architectural model.
   task automatic step(input logic [31:0] ins, input logic [31:0] rdat);
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd, wa;
      logic [31:0] a, b, se, ze, res, npc, wdat;
      logic        wen, mw, alu_chk, link;
      @(negedge clk);
      instr    = ins;
      readData = rdat;
      #1;
      op = ins[31:26]; fn = ins[5:0];
      rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
      a  = m_regs[rs]; b = m_regs[rt];
      se = {{16{ins[15]}}, ins[15:0]};
      ze = {16'h0, ins[15:0]};
      npc = m_pc + 32'd4;
      wen = 1'b0; mw = 1'b0; alu_chk = 1'b1; link = 1'b0;
      res = 32'h0; wa = rt; wdat = 32'h0;
      case (op)
         6'h00: begin
            wa = rd; wen = 1'b1;
            case (fn)
               6'h20: res = a + b;
               6'h22: res = a - b;
               6'h24: res = a & b;
               6'h25: res = a | b;
               6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               default: begin wen = 1'b0; res = 32'h0; end
            endcase
         end
         6'h08: begin res = a + se; wen = 1'b1; end
         6'h0A: begin res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; wen = 1'b1; end
         6'h0D: begin res = a | ze; wen = 1'b1; end
         6'h23: begin res = a + se; wen = 1'b1; end
         6'h2B: begin res = a + se; mw = 1'b1; end
         6'h04: begin
            res = a - b;
            if (a == b) npc = m_pc + 32'd4 + (se << 2);
         end
         6'h02: begin alu_chk = 1'b0; npc = {npc[31:28], ins[25:0], 2'b00}; end
`ifdef MIPS_JAL_EN
         6'h03: begin
            alu_chk = 1'b0; wen = 1'b1; wa = 5'd31; link = 1'b1;
            wdat = m_pc + 32'd4;
            npc = {npc[31:28], ins[25:0], 2'b00};
         end
`endif
         default: res = 32'h0;
      endcase
      if (!link) wdat = (op == 6'h23) ? rdat : res;
      if (reset) mw = 1'b0;
      check("writeData", writeData, b);
      check("memWrite", {31'd0, memWrite}, {31'd0, mw});
      if (alu_chk && !reset) check("aluout", aluout, res);
      last_alu = aluout; last_wd = writeData; last_mw = {31'd0, memWrite};
      @(posedge clk);
      if (reset) begin
         m_pc = 32'h0;
         for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      end else begin
         m_pc = npc;
         if (wen && wa != 5'd0) m_regs[wa] = wdat;
      end
      #1;
      check("pc", pc, m_pc);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      logic [5:0]  fn;
      rs  = 5'($urandom_range(0, 7));
      rt  = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      imm = 16'($urandom);
      case ($urandom_range(0, 4))
         0: fn = 6'h20;
         1: fn = 6'h22;
         2: fn = 6'h24;
         3: fn = 6'h25;
         default: fn = 6'h2A;
      endcase
      case ($urandom_range(0, 11))
         0, 11: return {6'h00, rs, rt, rd, 5'd0, fn};
         1:  return {6'h00, rs, rt, rd, 5'($urandom), 6'($urandom)};
         2:  return {6'h08, rs, rt, imm};
         3:  return {6'h0A, rs, rt, imm};
         4:  return {6'h0D, rs, rt, imm};
         5:  return {6'h23, rs, rt, imm};
         6:  return {6'h2B, rs, rt, imm};
         7: begin
            if ($urandom_range(0, 1) == 1) rt = rs;
            return {6'h04, rs, rt, 16'($urandom_range(0, 15)) - 16'd8};
         end
         8:  return {6'h02, 26'($urandom)};
         9:  return {6'h03, 26'($urandom)};
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_pc", pc, 32'h0);
      m_pc = 32'h0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      reset = 1'b0;

      step(32'h0000_0000, 32'h0);
      check("pc_inc4", pc, 32'h4);
      step(32'h0000_0000, 32'h0);
      check("pc_inc8", pc, 32'h8);

      step(32'h2022_0002, 32'h0); check("addi", last_alu, 32'd2);
      step(32'h3423_0004, 32'h0); check("ori", last_alu, 32'd4);
      step(32'h2824_0003, 32'h0); check("slti", last_alu, 32'd1);
      step(32'h0082_1820, 32'h0); check("add", last_alu, 32'd3);
      step(32'h0064_0822, 32'h0); check("sub", last_alu, 32'd2);
      step(32'h2001_FFFC, 32'h0); check("addi_neg", last_alu, 32'hFFFF_FFFC);
      step(32'h3407_8000, 32'h0); check("ori_zext", last_alu, 32'h0000_8000);
      step(32'h2000_0005, 32'h0);
      step(32'h0000_3025, 32'h0); check("r0_read", last_alu, 32'h0);
      step(32'h2001_0010, 32'h0);
      step(32'h2002_0007, 32'h0);
      step(32'hAC22_0008, 32'h0);
      check("sw_addr", last_alu, 32'd24);
      check("sw_data", last_wd, 32'd7);
      check("sw_we", last_mw, 32'd1);
      step(32'h8C25_0008, 32'hDEAD_BEEF);
      step(32'h0005_3025, 32'h0); check("lw_back", last_wd, 32'hDEAD_BEEF);
      step(32'h2001_FFFF, 32'h0);
      step(32'h2002_0003, 32'h0);
      step(32'h0022_302A, 32'h0); check("slt_signed", last_alu, 32'd1);
      step(32'h0800_0010, 32'h0); check("j_pc", pc, 32'h40);
      step(32'h1000_0002, 32'h0); check("beq_taken", pc, 32'h4C);
      step(32'h1020_0002, 32'h0); check("beq_not", pc, 32'h50);
      step(32'hFC00_0000, 32'h0);
      check("undef_pc", pc, 32'h54);
      check("undef_alu", last_alu, 32'h0);

      reset = 1'b1;
      step(32'hAC22_0008, 32'h0);
      check("rst_mid_pc", pc, 32'h0);
      check("rst_mid_we", last_mw, 32'h0);
      reset = 1'b0;

      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) reset = 1'b1;
         step(rand_instr(), 32'($urandom));
         reset = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mips_core.md
Name: mips_core

Overview:
Single-cycle 32-bit MIPS integer core (harvard style): fetches one instruction per clock from external instruction memory via pc/instr and accesses external data memory via aluout/writeData/readData/memWrite. Contains PC register, 32x32 register file, main/ALU decoders, sign/zero extenders and ALU. Sits between the top-level instruction ROM and data RAM.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
pc  output  32  current instruction address (registered).
instr  input  32  instruction word at pc (combinational from imem).
memWrite  output  1  data-memory write strobe (sw only).
aluout  output  32  ALU result; data-memory address for lw/sw.
writeData  output  32  register rt value; store data for sw.
readData  input  32  data-memory read data for lw.

Behaviour:
- Reset (reset=1 at rising edge): pc<=RESET_PC; all 32 registers <=0; no register write from the current instr. memWrite forced 0 while reset=1.
- Single-cycle: decode/execute combinational from instr; pc and register file update at next rising edge. aluout/writeData/memWrite valid same cycle as instr.
- Register file: 2 async read ports (rs, rt), 1 sync write port; $0 reads 0, writes ignored. Write-then-read across edges (no internal bypass needed).
- Supported: R-type (op 000000) add 100000, sub 100010, and 100100, or 100101, slt 101010; addi 001000, slti 001010, ori 001101, lw 100011, sw 101011, beq 000100, j 000010.
- Immediates: sign-extended for addi/slti/lw/sw/beq; zero-extended for ori.
- Arithmetic 32-bit wrap-around; no overflow exceptions. slt/slti signed compare, result 32'h1 or 32'h0.
- Destination: R-type writes rd; addi/ori/slti/lw write rt. lw writes readData; others write aluout.
- sw: memWrite=1, aluout=rs+signext(imm), writeData=rt; no reg write.
- beq: ALU computes rs-rt; if zero, pc<=pc+4+(signext(imm)<<2) else pc+4; no reg write; memWrite=0.
- j: pc<={pc_plus4[31:28], instr[25:0], 2'b00}.
- Default next pc = pc+4 (wraps at 2^32).
- Unknown opcode or unknown R-type funct: treated as nop (no reg write, memWrite=0, pc+4); aluout value don't-care but must be defined (drive 0).
- reset asserted mid-program: takes priority over any pending write/branch that cycle.

Optional Feature:
Macro MIPS_JAL_EN. Defined: adds jal (op 000011): pc<=jump target, $31<=pc+4, memWrite=0. Undefined: op 000011 is an unknown opcode (nop, pc+4, no write).

Test Plan:
- Reset 1 cycle -> pc=0; after release pc increments 0,4,8 each clock; reassert reset mid-run -> pc=0 at next edge.
- From reset, addi $2,$1,2 (32'h20220002) -> aluout=2; ori $3,$1,4 -> aluout=4; slti $4,$1,3 -> aluout=1; subsequent add $3,$4,$2 (funct 100000) -> aluout=3.
- sub $1,$3,$4 after above -> aluout=2; or/and/slt with $1=5,$2=3 -> 7, 1, 0; slt with $1=-1,$2=3 -> 1 (signed).
- addi $1,$0,-4 (imm 16'hFFFC) -> aluout=32'hFFFF_FFFC; ori with imm 16'h8000 -> 32'h0000_8000 (zero-extend); write to $0 then read -> 0.
- sw $2,8($1) with $1=16,$2=7 -> memWrite=1, aluout=24, writeData=7; lw $5,8($1), readData=32'hDEAD_BEEF -> $5 reads back DEADBEEF.
- beq taken (equal regs, imm=2) at pc=0x10 -> next pc=0x1C; not taken -> 0x14; j 26'h10 -> pc=0x40; undefined opcode -> pc+4, no state change.
